// File: rtl/enigma_sink.sv
// enigma_sink: port C responder for the enigma buffer.
// Tracks in-flight IDs, queues work, releases each after a QoS-timed service.
//
// Ports:
//   clk, rst_n                           clock, async active-low reset
//   valid_c, payload_c, id_c, qos_c      incoming port C transaction
//   ready_c, conflict_c                  accept / busy-ID response
//   release_c, releaseid_c               one-cycle release pulse + ID
//   stall                                freezes the service timer
//   done_vld, done_payload, done_qos     completion record
//   busy_cnt, conflict_cnt               occupancy, saturating conflict count
module enigma_sink #(
  parameter int DEPTH    = 4,
  parameter int LAT_BASE = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_c,
  input  logic [127:0]               payload_c,
  input  logic [5:0]                 id_c,
  input  logic [1:0]                 qos_c,
  output logic                       ready_c,
  output logic                       conflict_c,
  output logic                       release_c,
  output logic [5:0]                 releaseid_c,
  input  logic                       stall,
  output logic                       done_vld,
  output logic [127:0]               done_payload,
  output logic [1:0]                 done_qos,
  output logic [$clog2(DEPTH+1)-1:0] busy_cnt,
  output logic [15:0]                conflict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(LAT_BASE + 4);
  localparam logic [TW-1:0] LAT_TOP = TW'(LAT_BASE + 3);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RELEASE
  } state_t;

  logic [127:0] pay_mem [DEPTH];
  logic [5:0]   id_mem  [DEPTH];
  logic [1:0]   qos_mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [63:0]   inflight;
  logic [63:0]   inflight_n;
  logic [TW-1:0] timer;
  state_t        state;

  logic          accept;
  logic          pop;
  logic [127:0]  head_pay;
  logic [5:0]    head_id;
  logic [1:0]    head_qos;

  assign head_pay = pay_mem[head];
  assign head_id  = id_mem[head];
  assign head_qos = qos_mem[head];

  assign ready_c    = count < CW'(DEPTH);
  assign conflict_c = valid_c & inflight[id_c];
  assign accept     = valid_c & ready_c & ~conflict_c;
  assign pop        = state == RELEASE;
  assign busy_cnt   = count;

  // Accept and pop never touch the same bit: an accepted ID is not in flight.
  always_comb begin
    inflight_n = inflight;
    if (pop)
      inflight_n[head_id] = 1'b0;
    if (accept)
      inflight_n[id_c] = 1'b1;
  end

  // Storage is don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pay_mem[tail] <= payload_c;
      id_mem[tail]  <= id_c;
      qos_mem[tail] <= qos_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
    end else begin
      inflight <= inflight_n;
      if (accept)
        tail <= tail + AW'(1);
      if (pop)
        head <= head + AW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (conflict_c && conflict_cnt != 16'hFFFF)
      conflict_cnt <= conflict_cnt + 16'd1;
  end

  // Release outputs are registered on the SERVE->RELEASE edge so they are
  // stable for the whole RELEASE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      release_c    <= 1'b0;
      done_vld     <= 1'b0;
      releaseid_c  <= '0;
      done_payload <= '0;
      done_qos     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            timer <= LAT_TOP - TW'(head_qos);
            state <= SERVE;
          end
        end
        SERVE: begin
          if (!stall) begin
            timer <= timer - TW'(1);
            if (timer == TW'(1)) begin
              state        <= RELEASE;
              release_c    <= 1'b1;
              done_vld     <= 1'b1;
              releaseid_c  <= head_id;
              done_payload <= head_pay;
              done_qos     <= head_qos;
            end
          end
        end
        RELEASE: begin
          state        <= IDLE;
          release_c    <= 1'b0;
          done_vld     <= 1'b0;
          releaseid_c  <= '0;
          done_payload <= '0;
          done_qos     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_sink.sv
// tb_enigma_sink: directed self-checking bench for enigma_sink.
// Scenario tasks run in sequence; expectations are hand-derived cycle counts.
module tb_enigma_sink;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_c = 1'b0;
  logic [127:0] payload_c = '0;
  logic [5:0]   id_c = '0;
  logic [1:0]   qos_c = '0;
  logic         ready_c;
  logic         conflict_c;
  logic         release_c;
  logic [5:0]   releaseid_c;
  logic         stall = 1'b0;
  logic         done_vld;
  logic [127:0] done_payload;
  logic [1:0]   done_qos;
  logic [2:0]   busy_cnt;
  logic [15:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  enigma_sink #(.DEPTH(4), .LAT_BASE(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_c(valid_c),
    .payload_c(payload_c),
    .id_c(id_c),
    .qos_c(qos_c),
    .ready_c(ready_c),
    .conflict_c(conflict_c),
    .release_c(release_c),
    .releaseid_c(releaseid_c),
    .stall(stall),
    .done_vld(done_vld),
    .done_payload(done_payload),
    .done_qos(done_qos),
    .busy_cnt(busy_cnt),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_c = 1'b0;
    stall   = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // After return we sit in the cycle where release_c is high (if ok).
  task automatic wait_rel(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (release_c === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic push(input logic [5:0] id, input logic [1:0] q,
                      input logic [127:0] p);
    valid_c   = 1'b1;
    id_c      = id;
    qos_c     = q;
    payload_c = p;
    tick();
    valid_c = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({release_c, done_vld, releaseid_c, done_qos} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctl: got %0h expected 0",
               {release_c, done_vld, releaseid_c, done_qos});
    end
    checks++;
    if (done_payload !== 128'd0 || busy_cnt !== 3'd0 ||
        conflict_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: pay %0h busy %0d ccnt %0d expected 0",
               done_payload, busy_cnt, conflict_cnt);
    end
    checks++;
    if (ready_c !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", ready_c);
    end
    do_reset();
  endtask

  task automatic test_single();
    int k;
    bit ok;
    logic [127:0] p;
    p = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    do_reset();
    push(6'd5, 2'd3, p);
    k = cyc;
    checks++;
    if (busy_cnt !== 3'd1) begin
      errors++;
      $display("FAIL single_busy1: got %0d expected 1", busy_cnt);
    end
    wait_rel(ok);
    checks++;
    if (!ok || cyc - k != 5) begin
      errors++;
      $display("FAIL single_time: got edge+%0d ok %0b expected edge+5",
               cyc - k, ok);
    end
    checks++;
    if (releaseid_c !== 6'd5 || done_vld !== 1'b1 || done_qos !== 2'd3) begin
      errors++;
      $display("FAIL single_id: got id %0d vld %b qos %0d expected 5 1 3",
               releaseid_c, done_vld, done_qos);
    end
    checks++;
    if (done_payload !== p) begin
      errors++;
      $display("FAIL single_pay: got %0h expected %0h", done_payload, p);
    end
    tick();
    checks++;
    if (release_c !== 1'b0 || busy_cnt !== 3'd0) begin
      errors++;
      $display("FAIL single_after: rel %b busy %0d expected 0 0",
               release_c, busy_cnt);
    end
  endtask

  task automatic test_qos_sweep();
    int prev;
    bit ok;
    logic [127:0] p;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      p = {32'(i + 1), 32'hDEAD_0000, 32'(i * 7), 32'hCAFE_F00D};
      push(6'(i + 1), 2'(3 - i), p);
      if (i == 0)
        prev = cyc + 1;
    end
    // prev holds the cycle number after the first accept edge minus one
    prev = prev - 1;
    for (int i = 0; i < 4; i++) begin
      p = {32'(i + 1), 32'hDEAD_0000, 32'(i * 7), 32'hCAFE_F00D};
      wait_rel(ok);
      checks++;
      if (!ok || releaseid_c !== 6'(i + 1)) begin
        errors++;
        $display("FAIL sweep_id%0d: got %0d ok %0b expected %0d",
                 i, releaseid_c, ok, i + 1);
      end
      checks++;
      if (cyc + 1 - prev != 6 + i) begin
        errors++;
        $display("FAIL sweep_gap%0d: got %0d expected %0d",
                 i, cyc + 1 - prev, 6 + i);
      end
      checks++;
      if (done_payload !== p || done_qos !== 2'(3 - i)) begin
        errors++;
        $display("FAIL sweep_pay%0d: got %0h q%0d expected %0h q%0d",
                 i, done_payload, done_qos, p, 3 - i);
      end
      prev = cyc + 1;
      tick();
    end
  endtask

  task automatic test_conflict();
    bit ok;
    do_reset();
    push(6'd9, 2'd0, 128'h9);
    valid_c = 1'b1;
    id_c    = 6'd9;
    qos_c   = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (conflict_c !== 1'b1) begin
        errors++;
        $display("FAIL conf_flag%0d: got %b expected 1", i, conflict_c);
      end
      tick();
    end
    checks++;
    if (conflict_cnt !== 16'd3 || busy_cnt !== 3'd1) begin
      errors++;
      $display("FAIL conf_cnt: cnt %0d busy %0d expected 3 1",
               conflict_cnt, busy_cnt);
    end
    id_c      = 6'd10;
    payload_c = 128'hA;
    #1;
    checks++;
    if (conflict_c !== 1'b0) begin
      errors++;
      $display("FAIL conf_id10: got %b expected 0", conflict_c);
    end
    tick();
    valid_c = 1'b0;
    checks++;
    if (busy_cnt !== 3'd2) begin
      errors++;
      $display("FAIL conf_acc10: got %0d expected 2", busy_cnt);
    end
    wait_rel(ok);
    checks++;
    if (!ok || releaseid_c !== 6'd9) begin
      errors++;
      $display("FAIL conf_rel9: got %0d ok %0b expected 9", releaseid_c, ok);
    end
    // Same ID arriving during its own release is still a conflict.
    valid_c   = 1'b1;
    id_c      = 6'd9;
    payload_c = 128'h99;
    #1;
    checks++;
    if (conflict_c !== 1'b1) begin
      errors++;
      $display("FAIL conf_relsame: got %b expected 1", conflict_c);
    end
    tick();
    checks++;
    if (conflict_c !== 1'b0) begin
      errors++;
      $display("FAIL conf_cleared: got %b expected 0", conflict_c);
    end
    tick();
    valid_c = 1'b0;
    checks++;
    if (busy_cnt !== 3'd2 || conflict_cnt !== 16'd4) begin
      errors++;
      $display("FAIL conf_reacc: busy %0d cnt %0d expected 2 4",
               busy_cnt, conflict_cnt);
    end
    wait_rel(ok);
    checks++;
    if (!ok || releaseid_c !== 6'd10) begin
      errors++;
      $display("FAIL conf_rel10: got %0d ok %0b expected 10",
               releaseid_c, ok);
    end
    tick();
    wait_rel(ok);
    checks++;
    if (!ok || releaseid_c !== 6'd9 || done_payload !== 128'h99) begin
      errors++;
      $display("FAIL conf_rel9b: got %0d ok %0b expected 9", releaseid_c, ok);
    end
    tick();
  endtask

  task automatic test_full();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++)
      push(6'(20 + i), 2'd3, 128'(20 + i));
    checks++;
    if (ready_c !== 1'b0 || busy_cnt !== 3'd4) begin
      errors++;
      $display("FAIL full_ready: rdy %b busy %0d expected 0 4",
               ready_c, busy_cnt);
    end
    valid_c   = 1'b1;
    id_c      = 6'd24;
    qos_c     = 2'd3;
    payload_c = 128'd24;
    wait_rel(ok);
    checks++;
    if (!ok || releaseid_c !== 6'd20 || ready_c !== 1'b0) begin
      errors++;
      $display("FAIL full_rel: id %0d rdy %b ok %0b expected 20 0",
               releaseid_c, ready_c, ok);
    end
    tick();
    checks++;
    if (ready_c !== 1'b1 || busy_cnt !== 3'd3) begin
      errors++;
      $display("FAIL full_reopen: rdy %b busy %0d expected 1 3",
               ready_c, busy_cnt);
    end
    tick();
    valid_c = 1'b0;
    checks++;
    if (busy_cnt !== 3'd4) begin
      errors++;
      $display("FAIL full_acc5: got %0d expected 4", busy_cnt);
    end
    wait_rel(ok);
    checks++;
    if (!ok || releaseid_c !== 6'd21) begin
      errors++;
      $display("FAIL full_rel21: got %0d ok %0b", releaseid_c, ok);
    end
    tick();
    wait_rel(ok);
    checks++;
    if (!ok || releaseid_c !== 6'd22 || busy_cnt !== 3'd3) begin
      errors++;
      $display("FAIL full_rel22: id %0d busy %0d expected 22 3",
               releaseid_c, busy_cnt);
    end
    // Accept and pop on the same edge leaves occupancy unchanged.
    push(6'd25, 2'd3, 128'd25);
    checks++;
    if (busy_cnt !== 3'd3) begin
      errors++;
      $display("FAIL full_samecnt: got %0d expected 3", busy_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      wait_rel(ok);
      checks++;
      if (!ok || releaseid_c !== 6'(23 + i) ||
          done_payload !== 128'(23 + i)) begin
        errors++;
        $display("FAIL full_drain%0d: got %0d expected %0d",
                 i, releaseid_c, 23 + i);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int k;
    bit ok;
    do_reset();
    push(6'd7, 2'd3, 128'h77);
    k = cyc;
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++)
      tick();
    stall = 1'b0;
    wait_rel(ok);
    checks++;
    if (!ok || cyc - k != 10 || releaseid_c !== 6'd7) begin
      errors++;
      $display("FAIL stall_time: got edge+%0d id %0d expected edge+10 id 7",
               cyc - k, releaseid_c);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit ok;
    do_reset();
    push(6'd30, 2'd0, 128'h30);
    push(6'd31, 2'd0, 128'h31);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({release_c, done_vld, releaseid_c, done_qos} !== 10'd0 ||
        done_payload !== 128'd0 || busy_cnt !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_zero: rel %b busy %0d expected 0 0",
               release_c, busy_cnt);
    end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (release_c !== 1'b0)
        seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstmid_norel: got release expected none");
    end
    valid_c   = 1'b1;
    id_c      = 6'd30;
    qos_c     = 2'd3;
    payload_c = 128'h300;
    #1;
    checks++;
    if (conflict_c !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_reuse: got %b expected 0", conflict_c);
    end
    tick();
    valid_c = 1'b0;
    wait_rel(ok);
    checks++;
    if (!ok || releaseid_c !== 6'd30 || done_payload !== 128'h300) begin
      errors++;
      $display("FAIL rstmid_rel: got %0d ok %0b expected 30",
               releaseid_c, ok);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_qos_sweep();
    test_conflict();
    test_full();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
